viterbi_chan_err_inj: RTL and testbench

//  Channel stage between the rate-1/2 convolutional encoder and the Viterbi decoder.

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/viterbi_lfsr16.sv | 26 ++
 rtl/viterbi_chan_err_inj.sv | 98 +++++++++
 tb/tb_viterbi_chan_err_inj.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types, constants and the LFSR step used by the Viterbi channel
// stage and its stimulus generator.
package viterbi_pkg;

    // One rate-1/2 encoded symbol, {g1, g0}
    typedef logic [1:0] sym_t;

    // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Single Galois step: shift right, fold the polynomial in when a one falls out
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        logic [15:0] shifted;
        shifted = {1'b0, state[15:1]};
        if (state[0]) begin
            shifted = shifted ^ LFSR_POLY;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/viterbi_lfsr16.sv
// 16-bit Galois LFSR that steps only when told to, so the sequence is tied
// to the number of advances rather than to wall-clock cycles.
module viterbi_lfsr16
    import viterbi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_state;

    // Load the seed on reset, otherwise step once per advance request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= seed;
        end else if (adv) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign q = r_state;

endmodule

// File: rtl/viterbi_chan_err_inj.sv
// Channel stage between the convolutional encoder and the Viterbi decoder.
// Registers each symbol and, when allowed, flips exactly one of its bits.
// Error positions come from a seeded LFSR gated by a threshold and a
// minimum clean-symbol gap, so the decoder never sees two errors closer
// together than it can correct.
module viterbi_chan_err_inj
    import viterbi_pkg::*;
#(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MIN_GAP = 8,
    parameter int unsigned CT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sym_valid_i,
    input  logic [1:0]      sym_i,
    input  logic            err_en_i,
    input  logic [7:0]      err_thresh_i,
    output logic            sym_valid_o,
    output logic [1:0]      sym_o,
    output logic [1:0]      err_inj_o,
    output logic [CT_W-1:0] bad_bit_ct_o
);

    // An all-zero seed would lock the LFSR, so it is swapped for 1
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  GAP_MAX  = 8'(MIN_GAP);
    localparam logic [CT_W-1:0] CT_MAX = {CT_W{1'b1}};
    localparam logic [CT_W-1:0] CT_ONE = {{(CT_W-1){1'b0}}, 1'b1};

    logic [15:0]     w_lfsr;
    logic            w_unusedLfsrHi;
    logic            w_inject;
    sym_t            w_mask;

    logic            r_symValid;
    sym_t            r_sym;
    sym_t            r_errInj;
    logic [7:0]      r_gapCt;
    logic [CT_W-1:0] r_badCt;

    // The LFSR steps on every accepted symbol, even with injection disabled,
    // so a given symbol index always sees the same random value
    viterbi_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (sym_valid_i),
        .seed (SEED_EFF),
        .q    (w_lfsr)
    );

    // Only the low byte and bit 8 steer injection; the rest is pure state
    assign w_unusedLfsrHi = ^w_lfsr[15:9];

    // Decide on the pre-advance LFSR value; bit 8 picks which bit to flip
    always_comb begin
        w_inject = 1'b0;
        w_mask   = 2'b00;
        if (err_en_i && (w_lfsr[7:0] < err_thresh_i) && (r_gapCt >= GAP_MAX)) begin
            w_inject = 1'b1;
        end
        if (w_inject) begin
            w_mask = w_lfsr[8] ? 2'b10 : 2'b01;
        end
    end

    // Output register, gap guard and saturating corrupted-bit counter;
    // everything except the valid flag freezes while the input is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_symValid <= 1'b0;
            r_sym      <= 2'b00;
            r_errInj   <= 2'b00;
            r_gapCt    <= GAP_MAX;
            r_badCt    <= '0;
        end else begin
            r_symValid <= sym_valid_i;
            if (sym_valid_i) begin
                r_sym    <= sym_i ^ w_mask;
                r_errInj <= w_mask;
                if (w_inject) begin
                    r_gapCt <= 8'h00;
                    if (r_badCt != CT_MAX) begin
                        r_badCt <= r_badCt + CT_ONE;
                    end
                end else if (r_gapCt < GAP_MAX) begin
                    r_gapCt <= r_gapCt + 8'h01;
                end
            end
        end
    end

    assign sym_valid_o  = r_symValid;
    assign sym_o        = r_sym;
    assign err_inj_o    = r_errInj;
    assign bad_bit_ct_o = r_badCt;

endmodule

// File: tb/tb_viterbi_chan_err_inj.sv
// Self-checking bench for the Viterbi channel error injector. A reference
// model computes each expected output when the stimulus is driven and
// queues it; a monitor pops and compares one entry per clock. A second
// instance with a 3-bit counter exercises counter saturation.
module tb_viterbi_chan_err_inj;

    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          MIN_GAP = 8;

    typedef struct {
        logic        valid;
        logic [1:0]  sym;
        logic [1:0]  mask;
        logic [15:0] ct;
        logic [2:0]  sat;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        sym_valid_i;
    logic [1:0]  sym_i;
    logic        err_en_i;
    logic [7:0]  err_thresh_i;
    logic        sym_valid_o;
    logic [1:0]  sym_o;
    logic [1:0]  err_inj_o;
    logic [15:0] bad_bit_ct_o;
    logic        satValid;
    logic [1:0]  satSym;
    logic [1:0]  satMask;
    logic [2:0]  satCt;

    int checks = 0;
    int errors = 0;

    entry_t     expQ[$];
    logic [1:0] obsMasks[$];
    logic [1:0] savedMasks[$];

    logic [15:0] mLfsr;
    logic [7:0]  mGap;
    logic [15:0] mCt;
    logic [2:0]  mSat;
    logic [1:0]  mLastSym;
    logic [1:0]  mLastMask;
    int          mInjCount;

    viterbi_chan_err_inj #(.SEED(SEED), .MIN_GAP(MIN_GAP), .CT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sym_valid_i  (sym_valid_i),
        .sym_i        (sym_i),
        .err_en_i     (err_en_i),
        .err_thresh_i (err_thresh_i),
        .sym_valid_o  (sym_valid_o),
        .sym_o        (sym_o),
        .err_inj_o    (err_inj_o),
        .bad_bit_ct_o (bad_bit_ct_o)
    );

    viterbi_chan_err_inj #(.SEED(SEED), .MIN_GAP(MIN_GAP), .CT_W(3)) dutSat (
        .clk          (clk),
        .rst          (rst),
        .sym_valid_i  (sym_valid_i),
        .sym_i        (sym_i),
        .err_en_i     (err_en_i),
        .err_thresh_i (err_thresh_i),
        .sym_valid_o  (satValid),
        .sym_o        (satSym),
        .err_inj_o    (satMask),
        .bad_bit_ct_o (satCt)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent LFSR model written from the tap positions 15, 13, 12, 10
    function automatic logic [15:0] refStep(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue what the
    // channel must show after the next rising edge
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                                 input logic en, input logic [7:0] th);
        entry_t     e;
        logic       inj;
        logic [1:0] m;
        @(negedge clk);
        rst          = r;
        sym_valid_i  = v;
        sym_i        = s;
        err_en_i     = en;
        err_thresh_i = th;
        if (r) begin
            mLfsr     = SEED;
            mGap      = 8'(MIN_GAP);
            mCt       = 16'h0;
            mSat      = 3'h0;
            mLastSym  = 2'b00;
            mLastMask = 2'b00;
            e.valid   = 1'b0;
        end else if (v) begin
            inj = en && (mLfsr[7:0] < th) && (mGap >= 8'(MIN_GAP));
            m   = inj ? (mLfsr[8] ? 2'b10 : 2'b01) : 2'b00;
            if (inj) begin
                mGap = 8'h00;
                mInjCount++;
                if (mCt != 16'hFFFF) mCt = mCt + 16'h1;
                if (mSat != 3'h7) mSat = mSat + 3'h1;
            end else if (mGap < 8'(MIN_GAP)) begin
                mGap = mGap + 8'h1;
            end
            mLfsr     = refStep(mLfsr);
            mLastSym  = s ^ m;
            mLastMask = m;
            e.valid   = 1'b1;
        end else begin
            e.valid = 1'b0;
        end
        e.sym  = mLastSym;
        e.mask = mLastMask;
        e.ct   = mCt;
        e.sat  = mSat;
        expQ.push_back(e);
    endtask

    // Scoreboard monitor: one queued expectation per driven cycle
    always @(posedge clk) begin
        entry_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (sym_valid_o !== e.valid) begin
                errors++;
                $display("[TB] FAIL sb_valid: got %b want %b at %0t", sym_valid_o, e.valid, $time);
            end
            checks++;
            if (sym_o !== e.sym) begin
                errors++;
                $display("[TB] FAIL sb_sym: got %b want %b at %0t", sym_o, e.sym, $time);
            end
            checks++;
            if (err_inj_o !== e.mask) begin
                errors++;
                $display("[TB] FAIL sb_mask: got %b want %b at %0t", err_inj_o, e.mask, $time);
            end
            checks++;
            if (bad_bit_ct_o !== e.ct) begin
                errors++;
                $display("[TB] FAIL sb_count: got %0d want %0d at %0t", bad_bit_ct_o, e.ct, $time);
            end
            checks++;
            if (satCt !== e.sat || satMask !== e.mask || satValid !== e.valid || satSym !== e.sym) begin
                errors++;
                $display("[TB] FAIL sb_sat: got ct %0d mask %b want ct %0d mask %b at %0t",
                         satCt, satMask, e.sat, e.mask, $time);
            end
            if (sym_valid_o === 1'b1) obsMasks.push_back(err_inj_o);
        end
    end

    // Wait for the last driven cycle to reach the outputs
    task automatic flush();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        checks++;
        if (sym_valid_o !== 1'b0 || sym_o !== 2'b00 || err_inj_o !== 2'b00 || bad_bit_ct_o !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v%b s%b m%b c%0d want all zero",
                     sym_valid_o, sym_o, err_inj_o, bad_bit_ct_o);
        end
    endtask

    task automatic test_passthrough();
        int nz;
        obsMasks.delete();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 8'($urandom));
        end
        flush();
        nz = 0;
        foreach (obsMasks[i]) if (obsMasks[i] != 2'b00) nz++;
        checks++;
        if (obsMasks.size() != 256 || nz != 0 || bad_bit_ct_o !== 16'h0) begin
            errors++;
            $display("[TB] FAIL passthrough: got %0d symbols %0d masked count %0d want 256 0 0",
                     obsMasks.size(), nz, bad_bit_ct_o);
        end
    endtask

    task automatic test_thresh_zero();
        int nz;
        obsMasks.delete();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b1, 8'h00);
        end
        flush();
        nz = 0;
        foreach (obsMasks[i]) if (obsMasks[i] != 2'b00) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("[TB] FAIL thresh_zero: got %0d masked symbols want 0", nz);
        end
    endtask

    task automatic test_inject_spacing();
        int injSeen;
        int lastIdx;
        int badGap;
        int badHot;
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        obsMasks.delete();
        mInjCount = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'hFF);
        end
        flush();
        injSeen = 0;
        lastIdx = -100;
        badGap  = 0;
        badHot  = 0;
        foreach (obsMasks[i]) begin
            if ($countones(obsMasks[i]) > 1) badHot++;
            if (obsMasks[i] != 2'b00) begin
                injSeen++;
                if (i - lastIdx < MIN_GAP + 1) badGap++;
                lastIdx = i;
            end
        end
        checks++;
        if (obsMasks.size() != 100 || obsMasks[0] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL first_error: got %0d symbols first mask %b want 100 and 01",
                     obsMasks.size(), obsMasks.size() > 0 ? obsMasks[0] : 2'bxx);
        end
        checks++;
        if (injSeen != mInjCount || injSeen < 11) begin
            errors++;
            $display("[TB] FAIL error_count: got %0d want %0d", injSeen, mInjCount);
        end
        checks++;
        if (badGap != 0 || badHot != 0) begin
            errors++;
            $display("[TB] FAIL gap_onehot: got %0d short gaps %0d multi-bit masks want 0 0", badGap, badHot);
        end
        savedMasks = obsMasks;
    endtask

    task automatic test_determinism();
        int diffs;
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        obsMasks.delete();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'hFF);
        end
        flush();
        diffs = 0;
        foreach (savedMasks[i]) if (i >= obsMasks.size() || obsMasks[i] !== savedMasks[i]) diffs++;
        checks++;
        if (diffs != 0 || obsMasks.size() != savedMasks.size()) begin
            errors++;
            $display("[TB] FAIL determinism: got %0d differing masks over %0d symbols want 0 over %0d",
                     diffs, obsMasks.size(), savedMasks.size());
        end
    endtask

    task automatic test_valid_toggle();
        int diffs;
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        obsMasks.delete();
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1'b0, 1'(i % 2 == 0), 2'($urandom_range(0, 3)), 1'b1, 8'hFF);
        end
        flush();
        diffs = 0;
        for (int i = 0; i < 60; i++) begin
            if (i >= obsMasks.size() || obsMasks[i] !== savedMasks[i]) diffs++;
        end
        checks++;
        if (diffs != 0 || obsMasks.size() != 60) begin
            errors++;
            $display("[TB] FAIL valid_toggle: got %0d differing masks over %0d symbols want 0 over 60",
                     diffs, obsMasks.size());
        end
    endtask

    task automatic test_mid_reset();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, 8'hFF);
        end
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 8'hFF);
        @(posedge clk);
        #2;
        checks++;
        if (sym_valid_o !== 1'b0 || bad_bit_ct_o !== 16'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_drop: got valid %b count %0d want 0 0", sym_valid_o, bad_bit_ct_o);
        end
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 8'hFF);
        @(posedge clk);
        #2;
        checks++;
        if (sym_valid_o !== 1'b1 || err_inj_o !== 2'b01 || sym_o !== 2'b01 || bad_bit_ct_o !== 16'h1) begin
            errors++;
            $display("[TB] FAIL mid_reset_rearm: got v%b m%b s%b c%0d want v1 m01 s01 c1",
                     sym_valid_o, err_inj_o, sym_o, bad_bit_ct_o);
        end
    endtask

    task automatic test_saturation();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        mInjCount = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b1, 8'hFF);
        end
        flush();
        checks++;
        if (satCt !== 3'b111 || bad_bit_ct_o !== 16'(mInjCount)) begin
            errors++;
            $display("[TB] FAIL saturation: got narrow %0d wide %0d want 7 and %0d",
                     satCt, bad_bit_ct_o, mInjCount);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 8'($urandom));
        end
        flush();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations want 0", expQ.size());
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst          = 1'b1;
        sym_valid_i  = 1'b0;
        sym_i        = 2'b00;
        err_en_i     = 1'b0;
        err_thresh_i = 8'h00;
        mInjCount    = 0;
        test_reset();
        test_passthrough();
        test_thresh_zero();
        test_inject_spacing();
        test_determinism();
        test_valid_toggle();
        test_mid_reset();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
